cu_fsm_irq: RTL and testbench
=============================

CU_FSM_IRQ -- requirements
Module: cu_fsm_irq

Interface
REQ-001 The parameter N_IRQ SHALL default to 4; it is the number of interrupt sources, legal range 1..8, and elaboration SHALL fail outside that range.
REQ-002 The parameter MEM_WAIT_EN SHALL default to 1; when 1, memory phases wait for mem_ready, and when 0, every memory phase completes in one cycle.
REQ-003 The port CLK SHALL be an input of width 1 and serve as the system clock; all state changes occur on its rising edge.
REQ-004 The port RST SHALL be an input of width 1 and serve as the asynchronous, active-high reset.
REQ-005 The port opcode SHALL be an input of width 7 carrying ir[6:0].
REQ-006 The port func3 SHALL be an input of width 3 carrying ir[14:12].
REQ-007 The port irq SHALL be an input of width N_IRQ carrying the raw interrupt lines, which are rising-edge sensitive.
REQ-008 The port irq_mask SHALL be an input of width N_IRQ; a 1 enables the corresponding source.
REQ-009 The port mie SHALL be an input of width 1 acting as the global interrupt enable.
REQ-010 The port mem_ready SHALL be an input of width 1 indicating that memory completes the current access this cycle.
REQ-011 The outputs PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken and mret_exec SHALL each be width 1 and act as write and read strobes.
REQ-012 The output irq_id SHALL have width 3 and hold the index of the last serviced source.
REQ-013 The output state_o SHALL have width 3 and carry the current state encoding.

Function
REQ-014 The states SHALL be encoded as INIT=0, FETCH=1, EXEC=2, WB=3 and INTR=4; all other encodings SHALL transition to INIT.
REQ-015 Strobes SHALL be combinational from the current state, opcode, func3 and mem_ready; every strobe not listed for a state SHALL be 0.
REQ-016 In INIT, all strobes SHALL be 0 and the next state SHALL be FETCH.
REQ-017 In FETCH, memRDEN1 SHALL be 1; the state SHALL advance to EXEC when mem_ready=1 or MEM_WAIT_EN=0, and hold otherwise.
REQ-018 In EXEC with LOAD (0000011), memRDEN2 SHALL be 1, PC_WE SHALL be 0, and the next state SHALL be WB.
REQ-019 In EXEC with STORE (0100011), memWE2 SHALL be 1; PC_WE SHALL be 1 only when mem_ready=1 or MEM_WAIT_EN=0, and EXEC SHALL hold otherwise with memWE2 kept high.
REQ-020 In EXEC with BRANCH (1100011), PC_WE SHALL be 1 and RF_WE SHALL be 0.
REQ-021 In EXEC with LUI, AUIPC, JAL, JALR, OP_IMM or OP_RG3, PC_WE and RF_WE SHALL both be 1.
REQ-022 In EXEC with SYS (1110011) and func3=000, mret_exec and PC_WE SHALL be 1; with any other func3 value, csr_WE, RF_WE and PC_WE SHALL be 1.
REQ-023 In EXEC with an unlisted opcode, PC_WE SHALL be 1 and all other strobes SHALL be 0.
REQ-024 In WB, memRDEN2 SHALL be held at 1; RF_WE and PC_WE SHALL be 1 only when mem_ready=1 or MEM_WAIT_EN=0, and WB SHALL hold otherwise.
REQ-025 An instruction boundary SHALL be any EXEC or WB cycle with PC_WE=1; at a boundary the next state SHALL be INTR if any enabled interrupt is pending, and FETCH otherwise.
REQ-026 In INTR, int_taken and PC_WE SHALL be 1, and the next state SHALL be FETCH; INTR SHALL last exactly one cycle.
REQ-027 Edge detection SHALL register irq each cycle into irq_prev, and pend[i] SHALL be set when irq[i]=1 and irq_prev[i]=0.
REQ-028 The enabled-pending vector SHALL be pend & irq_mask, gated by mie; sources that are pending but disabled SHALL remain pending.
REQ-029 On the boundary-to-INTR transition, irq_id SHALL load the lowest enabled pending index, and that pend bit SHALL clear on the same edge.
REQ-030 If a new edge arrives on a source in the same cycle that source's pend bit clears, the set SHALL win.
REQ-031 irq_id SHALL be zero-extended to 3 bits and SHALL hold its value until the next INTR.

Reset
REQ-032 While RST=1, asynchronously: state SHALL be INIT, pend and irq_prev SHALL be 0, irq_id SHALL be 0, and all strobes SHALL be 0.
REQ-033 A line already high when RST deasserts SHALL register one edge on the first clock after reset.
REQ-034 Assertion of RST mid-instruction SHALL abort the instruction with no further strobes issued.

Verification
REQ-035 Reset, then ADDI (0010011) with mem_ready=1 -> state_o sequence 0,1,2,1; PC_WE=RF_WE=1 only in the EXEC cycle.
REQ-036 LOAD with mem_ready=0 for 2 WB cycles then 1 -> WB lasts 3 cycles; memRDEN2=1 throughout; RF_WE and PC_WE are 1 only on cycle 3.
REQ-037 N_IRQ=4, mask=1111, mie=1, irq[1] and irq[2] pulsed together during EXEC of ADDI -> INTR follows with irq_id=1 and int_taken=1 for one cycle; the next instruction boundary gives INTR with irq_id=2.
REQ-038 mie=0, irq[0] pulsed -> no INTR occurs; set mie=1 -> INTR with irq_id=0 at the next boundary.
REQ-039 RST asserted in WB of a LOAD -> state_o=0 and all strobes 0 immediately, pend=0; FETCH follows one cycle after release.
REQ-040 MEM_WAIT_EN=0, STORE with mem_ready tied 0 -> a single EXEC cycle with memWE2=1 and PC_WE=1, followed by FETCH.

Source files
------------

// File: rtl/cu_fsm_irq.sv
// Multi-cycle control unit FSM with edge-triggered, masked, priority interrupts.
// Strobes decode combinationally from the state, the opcode, func3 and mem_ready.
module cu_fsm_irq #(
  parameter int N_IRQ       = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             mie,
  input  logic             mem_ready,
  output logic             PC_WE,
  output logic             RF_WE,
  output logic             memWE2,
  output logic             memRDEN1,
  output logic             memRDEN2,
  output logic             csr_WE,
  output logic             int_taken,
  output logic             mret_exec,
  output logic [2:0]       irq_id,
  output logic [2:0]       state_o
);

  if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_n_irq
    $error("cu_fsm_irq: N_IRQ must be in 1..8");
  end

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_prev_q, pend_q, pend_d;
  logic [N_IRQ-1:0] en, clr_oh;
  logic [2:0]       irq_id_q, irq_id_d, low_idx;
  logic             mem_go, boundary, take;

  assign mem_go = mem_ready | ~MEM_WAIT_EN;

  // Lowest enabled pending source; scanning downward lets the lowest index win.
  always_comb begin
    en      = pend_q & irq_mask & {N_IRQ{mie}};
    low_idx = 3'd0;
    clr_oh  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (en[i]) begin
        low_idx   = 3'(i);
        clr_oh    = '0;
        clr_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        memRDEN1 = 1'b1;
        if (mem_go) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD: begin
            memRDEN2 = 1'b1;
            state_d  = S_WB;
          end
          OP_STORE: begin
            memWE2 = 1'b1;
            PC_WE  = mem_go;
          end
          OP_BRANCH: PC_WE = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
            PC_WE = 1'b1;
            RF_WE = 1'b1;
          end
          OP_SYS: begin
            PC_WE = 1'b1;
            if (func3 == 3'b000) mret_exec = 1'b1;
            else begin
              csr_WE = 1'b1;
              RF_WE  = 1'b1;
            end
          end
          default: PC_WE = 1'b1;
        endcase
      end
      S_WB: begin
        memRDEN2 = 1'b1;
        RF_WE    = mem_go;
        PC_WE    = mem_go;
      end
      S_INTR: begin
        int_taken = 1'b1;
        PC_WE     = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
    boundary = ((state_q == S_EXEC) || (state_q == S_WB)) && PC_WE;
    take     = boundary && (|en);
    if (boundary) state_d = take ? S_INTR : S_FETCH;
  end

  // A fresh edge is OR-ed in after the clear so a simultaneous set wins.
  always_comb begin
    pend_d   = (pend_q & ~(take ? clr_oh : '0)) | (irq & ~irq_prev_q);
    irq_id_d = take ? low_idx : irq_id_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_INIT;
      irq_prev_q <= '0;
      pend_q     <= '0;
      irq_id_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      pend_q     <= pend_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign irq_id  = irq_id_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Directed-vector bench for cu_fsm_irq; the second instance runs with MEM_WAIT_EN=0.
module tb_cu_fsm_irq;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  // Strobe vector: {PC_WE,RF_WE,memWE2,memRDEN1,memRDEN2,csr_WE,int_taken,mret_exec}
  localparam logic [7:0] SB_NONE  = 8'h00;
  localparam logic [7:0] SB_FETCH = 8'h10;
  localparam logic [7:0] SB_ALU   = 8'hC0;
  localparam logic [7:0] SB_LDEX  = 8'h08;
  localparam logic [7:0] SB_WBGO  = 8'hC8;
  localparam logic [7:0] SB_INTR  = 8'h82;
  localparam logic [7:0] SB_PC    = 8'h80;
  localparam logic [7:0] SB_MRET  = 8'h81;
  localparam logic [7:0] SB_CSR   = 8'hC4;
  localparam logic [7:0] SB_STW   = 8'h20;
  localparam logic [7:0] SB_STGO  = 8'hA0;

  logic       CLK, RST;
  logic [6:0] opcode, op0;
  logic [2:0] func3;
  logic [3:0] irq, irq_mask;
  logic       mie, mem_ready;
  logic       PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec;
  logic [2:0] irq_id, state_o;
  logic       PC_WE0, RF_WE0, memWE20, memRDEN10, memRDEN20, csr_WE0, int_taken0, mret_exec0;
  logic [2:0] irq_id0, state_o0;
  int n_chk, n_fail;

  cu_fsm_irq #(.N_IRQ(4), .MEM_WAIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .irq(irq), .irq_mask(irq_mask),
    .mie(mie), .mem_ready(mem_ready), .PC_WE(PC_WE), .RF_WE(RF_WE), .memWE2(memWE2),
    .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .csr_WE(csr_WE), .int_taken(int_taken),
    .mret_exec(mret_exec), .irq_id(irq_id), .state_o(state_o)
  );

  cu_fsm_irq #(.N_IRQ(4), .MEM_WAIT_EN(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .opcode(op0), .func3(3'b000), .irq(4'b0000), .irq_mask(4'b0000),
    .mie(1'b0), .mem_ready(1'b0), .PC_WE(PC_WE0), .RF_WE(RF_WE0), .memWE2(memWE20),
    .memRDEN1(memRDEN10), .memRDEN2(memRDEN20), .csr_WE(csr_WE0), .int_taken(int_taken0),
    .mret_exec(mret_exec0), .irq_id(irq_id0), .state_o(state_o0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] sb();
    return {PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec};
  endfunction

  function automatic logic [7:0] sb0();
    return {PC_WE0, RF_WE0, memWE20, memRDEN10, memRDEN20, csr_WE0, int_taken0, mret_exec0};
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] st, input logic [7:0] s);
    #1;
    chk({tag, "_state"}, 8'(state_o), 8'(st));
    chk({tag, "_strb"}, sb(), s);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    RST = 1'b1; opcode = OP_IMM; op0 = OP_STORE; func3 = 3'b000;
    irq = 4'b0000; irq_mask = 4'b1111; mie = 1'b1; mem_ready = 1'b1;
    #2;
    expect_st("reset", 3'd0, SB_NONE);
    chk("reset_irq_id", 8'(irq_id), 8'd0);

    // ADDI: 0,1,2,1 ; dut0 STORE with mem_ready tied low runs alongside
    tick(); RST = 1'b0;
    expect_st("addi_init", 3'd0, SB_NONE);
    tick(); expect_st("addi_fetch", 3'd1, SB_FETCH);
    chk("nw_fetch_state", 8'(state_o0), 8'd1);
    tick(); expect_st("addi_exec", 3'd2, SB_ALU);
    chk("nw_store_state", 8'(state_o0), 8'd2);
    chk("nw_store_strb", sb0(), SB_STGO);
    tick(); expect_st("addi_next", 3'd1, SB_FETCH);
    chk("nw_after_store", 8'(state_o0), 8'd1);

    // FETCH waits on mem_ready
    mem_ready = 1'b0; opcode = OP_LOAD;
    expect_st("fetch_wait", 3'd1, SB_FETCH);
    tick(); expect_st("fetch_hold", 3'd1, SB_FETCH);
    mem_ready = 1'b1;

    // LOAD: WB stalls two cycles then completes on the third
    tick(); expect_st("ld_exec", 3'd2, SB_LDEX);
    mem_ready = 1'b0;
    tick(); expect_st("ld_wb1", 3'd3, SB_LDEX);
    tick(); expect_st("ld_wb2", 3'd3, SB_LDEX);
    tick(); mem_ready = 1'b1;
    expect_st("ld_wb3", 3'd3, SB_WBGO);
    opcode = OP_BRANCH;
    tick(); expect_st("ld_done", 3'd1, SB_FETCH);

    // Branch, MRET, CSR, unknown opcode
    tick(); expect_st("br_exec", 3'd2, SB_PC);
    opcode = OP_SYS; func3 = 3'b000;
    tick(); tick(); expect_st("mret_exec", 3'd2, SB_MRET);
    func3 = 3'b001;
    expect_st("csr_exec", 3'd2, SB_CSR);
    opcode = 7'b0000000;
    expect_st("unk_exec", 3'd2, SB_PC);

    // STORE stalls in EXEC with memWE2 held
    opcode = OP_STORE; func3 = 3'b000; mem_ready = 1'b0;
    expect_st("st_wait", 3'd2, SB_STW);
    tick(); expect_st("st_hold", 3'd2, SB_STW);
    mem_ready = 1'b1;
    expect_st("st_go", 3'd2, SB_STGO);
    opcode = OP_IMM;
    tick(); expect_st("st_done", 3'd1, SB_FETCH);

    // Two simultaneous edges: lowest index first, the other at the next boundary
    irq = 4'b0110;
    tick(); irq = 4'b0000;
    expect_st("irq_exec", 3'd2, SB_ALU);
    tick(); expect_st("intr1", 3'd4, SB_INTR);
    chk("intr1_id", 8'(irq_id), 8'd1);
    tick(); expect_st("intr1_after", 3'd1, SB_FETCH);
    chk("id_hold", 8'(irq_id), 8'd1);
    tick(); expect_st("irq2_exec", 3'd2, SB_ALU);
    tick(); expect_st("intr2", 3'd4, SB_INTR);
    chk("intr2_id", 8'(irq_id), 8'd2);

    // Global disable leaves the source pending until mie returns
    mie = 1'b0;
    tick(); irq = 4'b0001;
    expect_st("mie0_fetch", 3'd1, SB_FETCH);
    tick(); irq = 4'b0000;
    expect_st("mie0_exec", 3'd2, SB_ALU);
    tick(); expect_st("mie0_no_intr", 3'd1, SB_FETCH);
    mie = 1'b1;
    tick(); tick(); expect_st("mie1_intr", 3'd4, SB_INTR);
    chk("mie1_id", 8'(irq_id), 8'd0);

    // Reset in WB of a LOAD with a masked source pending; line stays high across release
    irq_mask = 4'b0111; opcode = OP_LOAD;
    tick(); irq = 4'b1000;
    tick(); mem_ready = 1'b0;
    tick(); expect_st("rst_pre_wb", 3'd3, SB_LDEX);
    chk("rst_pre_pend", 8'(dut.pend_q), 8'h08);
    RST = 1'b1;
    expect_st("rst_mid", 3'd0, SB_NONE);
    chk("rst_pend", 8'(dut.pend_q), 8'h00);
    chk("rst_id", 8'(irq_id), 8'd0);
    opcode = OP_IMM; mem_ready = 1'b1; irq_mask = 4'b1111;
    tick(); RST = 1'b0;
    expect_st("rel_init", 3'd0, SB_NONE);
    tick(); expect_st("rel_fetch", 3'd1, SB_FETCH);
    chk("rel_edge_pend", 8'(dut.pend_q), 8'h08);
    tick(); expect_st("rel_exec", 3'd2, SB_ALU);
    tick(); expect_st("rel_intr", 3'd4, SB_INTR);
    chk("rel_id", 8'(irq_id), 8'd3);
    tick(); expect_st("rel_after", 3'd1, SB_FETCH);
    chk("rel_pend_clr", 8'(dut.pend_q), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
